rvfi_commit_driver: RTL

Core-side producer of the 8-channel RVFI commit interface consumed by the verification monitor. Accepts up to `RETIRE_W` retired-instruction records per cycle from the ROB commit stage and buffers them in an in-order FIFO. Drains up to `CHANNELS` records per cycle onto registered RVFI channels, assigning consecutive `order` numbers. Also sanitises register data and produces sticky halt and error flags.

---
 rtl/rvfi_commit_driver_if.sv | 48 ++++
 rtl/rvfi_commit_driver.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rvfi_commit_driver_if.sv
// Bundles the ROB retire lanes and the RVFI commit channels of rvfi_commit_driver.
// The master side is the ROB (and the RVFI consumer); the slave side is the driver itself.
interface rvfi_commit_driver_if #(
   parameter int RETIRE_W = 2,
   parameter int CHANNELS = 8
);
   logic [RETIRE_W-1:0]       in_valid;
   logic                      in_ready;
   logic [RETIRE_W-1:0][31:0] in_inst, in_pc_rdata, in_pc_wdata;
   logic [RETIRE_W-1:0][4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
   logic [RETIRE_W-1:0][31:0] in_rs1_rdata, in_rs2_rdata, in_rd_wdata;
   logic [RETIRE_W-1:0][31:0] in_mem_addr, in_mem_rdata, in_mem_wdata;
   logic [RETIRE_W-1:0][3:0]  in_mem_rmask, in_mem_wmask;

   logic [CHANNELS-1:0]       rvfi_valid;
   logic [CHANNELS-1:0][63:0] rvfi_order;
   logic [CHANNELS-1:0][31:0] rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata;
   logic [CHANNELS-1:0][4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
   logic [CHANNELS-1:0][31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
   logic [CHANNELS-1:0][31:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
   logic [CHANNELS-1:0][3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
   logic                      halted;
   logic                      error;

   modport master (
      output in_valid, in_inst, in_pc_rdata, in_pc_wdata,
             in_rs1_addr, in_rs2_addr, in_rd_addr,
             in_rs1_rdata, in_rs2_rdata, in_rd_wdata,
             in_mem_addr, in_mem_rdata, in_mem_wdata, in_mem_rmask, in_mem_wmask,
      input  in_ready, rvfi_valid, rvfi_order, rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata,
             rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
             rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata,
             rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata, rvfi_mem_rmask, rvfi_mem_wmask,
             halted, error
   );

   modport slave (
      input  in_valid, in_inst, in_pc_rdata, in_pc_wdata,
             in_rs1_addr, in_rs2_addr, in_rd_addr,
             in_rs1_rdata, in_rs2_rdata, in_rd_wdata,
             in_mem_addr, in_mem_rdata, in_mem_wdata, in_mem_rmask, in_mem_wmask,
      output in_ready, rvfi_valid, rvfi_order, rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata,
             rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
             rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata,
             rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata, rvfi_mem_rmask, rvfi_mem_wmask,
             halted, error
   );
endinterface

// File: rtl/rvfi_commit_driver.sv
// Buffers retired-instruction records in an in-order FIFO and drains them onto
// registered RVFI channels with consecutive order numbers, sticky halt and error.
module rvfi_commit_driver #(
   parameter int RETIRE_W = 2,
   parameter int CHANNELS = 8,
   parameter int DEPTH    = 16
) (
   input logic                clk,
   input logic                rst,
   rvfi_commit_driver_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [31:0] inst, pc_rdata, pc_wdata;
      logic [4:0]  rs1_addr, rs2_addr, rd_addr;
      logic [31:0] rs1_rdata, rs2_rdata, rd_wdata;
      logic [31:0] mem_addr, mem_rdata, mem_wdata;
      logic [3:0]  mem_rmask, mem_wmask;
   } entry_t;

   function automatic logic is_halt(input entry_t e);
      return (e.pc_rdata == e.pc_wdata) || (e.inst == 32'h0000_0063) ||
             (e.inst == 32'h0000_006F) || (e.inst == 32'hF000_2013);
   endfunction

   // Reads of x0 and writes to x0 must always report zero data.
   function automatic entry_t sanitise(input entry_t e);
      entry_t r;
      r = e;
      if (e.rs1_addr == 5'd0) r.rs1_rdata = 32'd0;
      if (e.rs2_addr == 5'd0) r.rs2_rdata = 32'd0;
      if (e.rd_addr == 5'd0)  r.rd_wdata  = 32'd0;
      return r;
   endfunction

   entry_t                    mem_q [DEPTH];
   logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]             count_q, count_d;
   logic [63:0]               order_ctr_q, order_ctr_d;
   logic                      halted_q, halted_d, error_q, error_d;
   logic [CHANNELS-1:0]       valid_q, valid_d;
   entry_t [CHANNELS-1:0]     out_q, out_d;
   logic [CHANNELS-1:0][63:0] order_q, order_d;

   logic                      ready_s, prefix_s;
   logic [CW-1:0]             push_n_s, pop_n_s;
   entry_t [RETIRE_W-1:0]     lane_s;

   // Gather each retire lane into one record.
   always_comb begin
      for (int i = 0; i < RETIRE_W; i++) begin
         lane_s[i].inst      = bus.in_inst[i];
         lane_s[i].pc_rdata  = bus.in_pc_rdata[i];
         lane_s[i].pc_wdata  = bus.in_pc_wdata[i];
         lane_s[i].rs1_addr  = bus.in_rs1_addr[i];
         lane_s[i].rs2_addr  = bus.in_rs2_addr[i];
         lane_s[i].rd_addr   = bus.in_rd_addr[i];
         lane_s[i].rs1_rdata = bus.in_rs1_rdata[i];
         lane_s[i].rs2_rdata = bus.in_rs2_rdata[i];
         lane_s[i].rd_wdata  = bus.in_rd_wdata[i];
         lane_s[i].mem_addr  = bus.in_mem_addr[i];
         lane_s[i].mem_rdata = bus.in_mem_rdata[i];
         lane_s[i].mem_wdata = bus.in_mem_wdata[i];
         lane_s[i].mem_rmask = bus.in_mem_rmask[i];
         lane_s[i].mem_wmask = bus.in_mem_wmask[i];
      end
   end

   // Accept side: readiness, prefix check, push count and sticky error.
   always_comb begin
      ready_s  = halted_q || ((CW'(DEPTH) - count_q) >= CW'(RETIRE_W));
      prefix_s = ((bus.in_valid & (bus.in_valid + RETIRE_W'(1))) == '0);
      push_n_s = '0;
      if (ready_s && prefix_s && !halted_q) begin
         for (int i = 0; i < RETIRE_W; i++) begin
            push_n_s = push_n_s + CW'(bus.in_valid[i]);
         end
      end else begin
         push_n_s = '0;
      end
      error_d = error_q || !prefix_s || (!ready_s && (bus.in_valid != '0));
   end

   // Drain side: pop up to CHANNELS entries, stop emitting after the first halt.
   always_comb begin : drain_c
      entry_t e;
      logic   hit;
      e        = '0;
      hit      = 1'b0;
      halted_d = halted_q;
      valid_d  = '0;
      out_d    = '0;
      order_d  = '0;
      if (int'(count_q) > CHANNELS) begin
         pop_n_s = CW'(CHANNELS);
      end else begin
         pop_n_s = count_q;
      end
      for (int k = 0; k < CHANNELS; k++) begin
         e = mem_q[rd_ptr_q + AW'(k)];
         if ((k < int'(pop_n_s)) && !halted_q && !hit) begin
            valid_d[k] = 1'b1;
            out_d[k]   = sanitise(e);
            order_d[k] = order_ctr_q + 64'(k);
            if (is_halt(e)) begin
               hit      = 1'b1;
               halted_d = 1'b1;
            end else begin
               hit      = 1'b0;
            end
         end else begin
            valid_d[k] = 1'b0;
         end
      end
      rd_ptr_d    = rd_ptr_q + AW'(pop_n_s);
      wr_ptr_d    = wr_ptr_q + AW'(push_n_s);
      count_d     = count_q + push_n_s - pop_n_s;
      order_ctr_d = order_ctr_q + 64'(pop_n_s);
   end

   // FIFO storage; only valid lanes below the push count are written.
   always_ff @(posedge clk) begin
      for (int i = 0; i < RETIRE_W; i++) begin
         if (CW'(i) < push_n_s) begin
            mem_q[wr_ptr_q + AW'(i)] <= lane_s[i];
         end
      end
   end

   // Pointers, counters, sticky flags and the registered RVFI channels.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         order_ctr_q <= 64'd0;
         halted_q    <= 1'b0;
         error_q     <= 1'b0;
         valid_q     <= '0;
         out_q       <= '0;
         order_q     <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         order_ctr_q <= order_ctr_d;
         halted_q    <= halted_d;
         error_q     <= error_d;
         valid_q     <= valid_d;
         out_q       <= out_d;
         order_q     <= order_d;
      end
   end

   // Fan the registered channel records out onto the RVFI fields.
   always_comb begin
      bus.in_ready   = ready_s;
      bus.halted     = halted_q;
      bus.error      = error_q;
      bus.rvfi_valid = valid_q;
      bus.rvfi_order = order_q;
      for (int k = 0; k < CHANNELS; k++) begin
         bus.rvfi_inst[k]      = out_q[k].inst;
         bus.rvfi_pc_rdata[k]  = out_q[k].pc_rdata;
         bus.rvfi_pc_wdata[k]  = out_q[k].pc_wdata;
         bus.rvfi_rs1_addr[k]  = out_q[k].rs1_addr;
         bus.rvfi_rs2_addr[k]  = out_q[k].rs2_addr;
         bus.rvfi_rd_addr[k]   = out_q[k].rd_addr;
         bus.rvfi_rs1_rdata[k] = out_q[k].rs1_rdata;
         bus.rvfi_rs2_rdata[k] = out_q[k].rs2_rdata;
         bus.rvfi_rd_wdata[k]  = out_q[k].rd_wdata;
         bus.rvfi_mem_addr[k]  = out_q[k].mem_addr;
         bus.rvfi_mem_rdata[k] = out_q[k].mem_rdata;
         bus.rvfi_mem_wdata[k] = out_q[k].mem_wdata;
         bus.rvfi_mem_rmask[k] = out_q[k].mem_rmask;
         bus.rvfi_mem_wmask[k] = out_q[k].mem_wmask;
      end
   end
endmodule
